// File: rtl/camera_emu_pkg.sv
// Shared types and constants for the camera sensor emulator.
package camera_emu_pkg;

  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FRONT  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_BACK   = 3'd4,
    ST_VBLANK = 3'd5
  } emu_state_e;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_CONST   = 2'd2,
    PAT_FRAMEID = 2'd3
  } pat_sel_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/camera_emu_pattern.sv
// Combinational test-pattern generator: pixel value from (x, y), pattern
// select and the low nibble of the frame counter.
module camera_emu_pattern
  import camera_emu_pkg::*;
#(
  parameter logic [DATA_W-1:0] CONST_VAL = 12'hA5A
) (
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [1:0]        sel,
  input  logic [3:0]        frame_id,
  output logic [DATA_W-1:0] pixel
);

  // Pattern selection
  always_comb begin
    pixel = 12'h000;
    case (sel)
      PAT_RAMP:    pixel = x_in + y_in;
      PAT_CHECKER: pixel = (x_in[3] ^ y_in[3]) ? 12'hFFF : 12'h000;
      PAT_CONST:   pixel = CONST_VAL;
      PAT_FRAMEID: pixel = {frame_id, x_in[7:0]};
      default:     pixel = 12'h000;
    endcase
  end

endmodule

// File: rtl/camera_sensor_emu.sv
// Image-sensor emulator: pixel clock at clk/2 plus frame_valid/line_valid/data
// updated on pixclk falling edges so they are stable at every pixclk rise.
module camera_sensor_emu
  import camera_emu_pkg::*;
#(
  parameter int                H_ACTIVE    = 640,
  parameter int                V_ACTIVE    = 480,
  parameter int                H_BLANK     = 16,
  parameter int                FV_LV_DELAY = 4,
  parameter int                V_BLANK     = 32,
  parameter logic [DATA_W-1:0] CONST_VAL   = 12'hA5A
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sensor_nreset_in,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic              pixclk_out,
  output logic              frame_valid,
  output logic              line_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int B_MAX = max3(H_BLANK, V_BLANK, FV_LV_DELAY);
  localparam int B_W   = $clog2(B_MAX + 1);

  localparam logic [X_W-1:0] X_LAST  = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_ACTIVE - 1);
  localparam logic [B_W-1:0] B_DELAY = B_W'(FV_LV_DELAY);
  localparam logic [B_W-1:0] B_HBLK  = B_W'(H_BLANK);
  localparam logic [B_W-1:0] B_VBLK  = B_W'(V_BLANK);
  localparam logic [B_W-1:0] B_ONE   = B_W'(1);

  emu_state_e        state_q, state_d;
  logic              ph_q, ph_d;
  logic [B_W-1:0]    cnt_q, cnt_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [1:0]        pat_q, pat_d;
  logic [15:0]       fc_q, fc_d;
  logic              fv_q, fv_d;
  logic              lv_q, lv_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  logic [X_W-1:0]    pix_x_s;
  logic [Y_W-1:0]    pix_y_s;
  logic [DATA_W-1:0] pix_s;

  // Coordinates of the pixel that the coming tick would put on the bus
  always_comb begin
    if (state_q == ST_ACTIVE) begin
      pix_x_s = x_q + X_W'(1);
      pix_y_s = y_q;
    end else if (state_q == ST_HBLANK) begin
      pix_x_s = {X_W{1'b0}};
      pix_y_s = y_q + Y_W'(1);
    end else begin
      pix_x_s = {X_W{1'b0}};
      pix_y_s = y_q;
    end
  end

  camera_emu_pattern #(
    .CONST_VAL (CONST_VAL)
  ) u_pattern (
    .x_in     (DATA_W'(pix_x_s)),
    .y_in     (DATA_W'(pix_y_s)),
    .sel      (pat_q),
    .frame_id (fc_q[3:0]),
    .pixel    (pix_s)
  );

  // Next-state and next-output logic; state_q names the period on the bus
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    pat_d   = pat_q;
    fc_d    = fc_q;
    fv_d    = fv_q;
    lv_d    = lv_q;
    data_d  = data_q;

    if (!sensor_nreset_in) begin
      state_d = ST_IDLE;
      ph_d    = 1'b0;
      cnt_d   = {B_W{1'b0}};
      x_d     = {X_W{1'b0}};
      y_d     = {Y_W{1'b0}};
      fv_d    = 1'b0;
      lv_d    = 1'b0;
      data_d  = 12'h000;
    end else if (state_q == ST_IDLE) begin
      fv_d   = 1'b0;
      lv_d   = 1'b0;
      data_d = 12'h000;
      if (enable) begin
        state_d = ST_FRONT;
        ph_d    = 1'b1;
        cnt_d   = {B_W{1'b0}};
        x_d     = {X_W{1'b0}};
        y_d     = {Y_W{1'b0}};
        pat_d   = pattern_sel;
      end else begin
        ph_d = 1'b0;
      end
    end else if (!ph_q) begin
      ph_d = 1'b1;
    end else begin
      // Tick: load the outputs for the next pixel period
      ph_d   = 1'b0;
      fv_d   = 1'b1;
      lv_d   = 1'b0;
      data_d = 12'h000;
      case (state_q)
        ST_FRONT: begin
          if (cnt_q == B_DELAY) begin
            state_d = ST_ACTIVE;
            x_d     = pix_x_s;
            lv_d    = 1'b1;
            data_d  = pix_s;
          end else begin
            cnt_d = cnt_q + B_ONE;
          end
        end
        ST_ACTIVE: begin
          if (x_q == X_LAST) begin
            cnt_d   = B_ONE;
            state_d = (y_q == Y_LAST) ? ST_BACK : ST_HBLANK;
          end else begin
            x_d    = pix_x_s;
            lv_d   = 1'b1;
            data_d = pix_s;
          end
        end
        ST_HBLANK: begin
          if (cnt_q == B_HBLK) begin
            state_d = ST_ACTIVE;
            x_d     = pix_x_s;
            y_d     = pix_y_s;
            lv_d    = 1'b1;
            data_d  = pix_s;
          end else begin
            cnt_d = cnt_q + B_ONE;
          end
        end
        ST_BACK: begin
          if (cnt_q == B_DELAY) begin
            state_d = ST_VBLANK;
            cnt_d   = B_ONE;
            fv_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + B_ONE;
          end
        end
        ST_VBLANK: begin
          fv_d = 1'b0;
          if (cnt_q == B_VBLK) begin
            fc_d = fc_q + 16'd1;
            if (enable) begin
              state_d = ST_FRONT;
              cnt_d   = B_ONE;
              x_d     = {X_W{1'b0}};
              y_d     = {Y_W{1'b0}};
              pat_d   = pattern_sel;
              fv_d    = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + B_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          fv_d    = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= {B_W{1'b0}};
      x_q     <= {X_W{1'b0}};
      y_q     <= {Y_W{1'b0}};
      pat_q   <= 2'd0;
      fc_q    <= 16'd0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      data_q  <= 12'h000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pat_q   <= pat_d;
      fc_q    <= fc_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign pixclk_out  = ph_q;
  assign frame_valid = fv_q;
  assign line_valid  = lv_q;
  assign data_out    = data_q;
  assign frame_count = fc_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_camera_sensor_emu.sv
// Randomized bench for camera_sensor_emu against a per-frame sample-list model.
`timescale 1ns/1ps
module tb_camera_sensor_emu;

  localparam int          H  = 16;
  localparam int          V  = 4;
  localparam int          HB = 2;
  localparam int          D  = 1;
  localparam int          VB = 3;
  localparam logic [11:0] CV = 12'hA5A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sensor_nreset_in;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        pixclk_out;
  logic        frame_valid;
  logic        line_valid;
  logic [11:0] data_out;
  logic [15:0] frame_count;
  logic        busy;

  camera_sensor_emu #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .H_BLANK     (HB),
    .FV_LV_DELAY (D),
    .V_BLANK     (VB),
    .CONST_VAL   (CV)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sensor_nreset_in (sensor_nreset_in),
    .enable           (enable),
    .pattern_sel      (pattern_sel),
    .pixclk_out       (pixclk_out),
    .frame_valid      (frame_valid),
    .line_valid       (line_valid),
    .data_out         (data_out),
    .frame_count      (frame_count),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {frame_valid, line_valid, data} per pixclk period, in order.
  logic [13:0] exp_q[$];
  bit          running  = 1'b0;
  int          fc_mdl   = 0;
  logic        prev_pix = 1'b0;
  logic [13:0] prev_out = 14'h0000;

  function automatic logic [11:0] ref_pixel(input int sel, input int x, input int y, input int fc);
    case (sel)
      0:       return 12'((x + y) % 4096);
      1:       return ((((x / 8) + (y / 8)) % 2) == 1) ? 12'hFFF : 12'h000;
      2:       return CV;
      default: return 12'(((fc % 16) * 256) + (x % 256));
    endcase
  endfunction

  task automatic push_frame(input int sel, input int fc);
    for (int i = 0; i < D; i++) exp_q.push_back(14'h2000);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) exp_q.push_back({2'b11, ref_pixel(sel, x, y, fc)});
      if (y < V - 1) begin
        for (int i = 0; i < HB; i++) exp_q.push_back(14'h2000);
      end
    end
    for (int i = 0; i < D; i++) exp_q.push_back(14'h2000);
    for (int i = 0; i < VB; i++) exp_q.push_back(14'h0000);
  endtask

  always @(negedge clk) begin : mon
    logic [13:0] out_s;
    logic [13:0] e_s;
    out_s = {frame_valid, line_valid, data_out};
    if (!reset_n) begin
      exp_q.delete();
      running = 1'b0;
      fc_mdl  = 0;
    end else begin
      check_val("frame_count", {16'd0, frame_count}, fc_mdl % 65536);
      if (!running) begin
        check_val("idle_outputs", {16'd0, busy, pixclk_out, out_s}, 32'd0);
      end else begin
        check_val("busy", {31'd0, busy}, 32'd1);
        check_val("pixclk_period", {31'd0, pixclk_out}, {31'd0, !prev_pix});
        if (pixclk_out && exp_q.size() != 0) begin
          check_val("stable_at_rise", {18'd0, out_s}, {18'd0, prev_out});
          e_s = exp_q.pop_front();
          check_val("pixel_stream", {18'd0, out_s}, {18'd0, e_s});
          if (exp_q.size() == 0 && sensor_nreset_in) begin
            fc_mdl++;
            if (enable) push_frame(pattern_sel, fc_mdl);
            else running = 1'b0;
          end
        end
      end
      if (!sensor_nreset_in) begin
        exp_q.delete();
        running = 1'b0;
      end else if (!running && enable) begin
        exp_q.push_back(14'h0000);
        push_frame(pattern_sel, fc_mdl);
        running = 1'b1;
      end
    end
    prev_pix = pixclk_out;
    prev_out = out_s;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_pos(input int frame, input int remain);
    int k = 0;
    while (!(running && fc_mdl == frame && exp_q.size() <= remain) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_val("wait_frame_pos", {31'd0, k < 3000}, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (running && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_val("wait_idle", {31'd0, k < 3000}, 32'd1);
  endtask

  task automatic check_quiet(input string tag, input int fc);
    check_val({tag, "_pixclk"}, {31'd0, pixclk_out}, 32'd0);
    check_val({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
    check_val({tag, "_lv"}, {31'd0, line_valid}, 32'd0);
    check_val({tag, "_data"}, {20'd0, data_out}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_fc"}, {16'd0, frame_count}, fc);
  endtask

  initial begin
    reset_n          = 1'b0;
    sensor_nreset_in = 1'b1;
    enable           = 1'b0;
    pattern_sel      = 2'd0;
    #12;
    check_quiet("reset", 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_clks(6);

    // Pattern sweep: frames 0-1 ramp, 2 checker, 3 const, 4-5 frame id
    enable = 1'b1;
    wait_frame_pos(1, 50);
    pattern_sel = 2'd1;
    wait_frame_pos(2, 50);
    pattern_sel = 2'd2;
    wait_frame_pos(3, 50);
    pattern_sel = 2'd3;
    wait_frame_pos(5, 50);
    pattern_sel = 2'($urandom_range(0, 3));

    // Enable dropped during line 1 of frame 6
    wait_frame_pos(6, 50);
    enable = 1'b0;
    wait_idle();
    wait_clks(20);
    check_quiet("after_drop", 7);

    // Sensor reset during active video of frame 7
    enable = 1'b1;
    wait_frame_pos(7, 30);
    sensor_nreset_in = 1'b0;
    wait_clks(1);
    check_quiet("sensor_rst", 7);
    wait_clks(4);
    sensor_nreset_in = 1'b1;
    wait_frame_pos(7, 40);

    // Random pattern, enable and sensor-reset activity
    for (int r = 0; r < 10; r++) begin
      wait_clks($urandom_range(40, 260));
      case ($urandom_range(0, 3))
        0: enable = ~enable;
        1: begin
          sensor_nreset_in = 1'b0;
          wait_clks($urandom_range(1, 6));
          sensor_nreset_in = 1'b1;
        end
        default: pattern_sel = 2'($urandom_range(0, 3));
      endcase
    end
    enable = 1'b1;
    wait_clks(20);
    wait_frame_pos(fc_mdl, 40);

    // Async reset between clock edges, then a mid-frame pattern change
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_quiet("async_rst", 0);
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    pattern_sel = 2'd1;
    wait_frame_pos(0, 50);
    pattern_sel = 2'd2;
    wait_frame_pos(1, 50);
    enable = 1'b0;
    wait_idle();
    wait_clks(10);
    check_quiet("final", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
